// File: rtl/cpu_defs.sv
// cpu_defs: shared encodings for the fetch-side control logic.
//   - npc_sel_e : next-PC select codes driven on NPC_ctrl
//   - fsm_st_e  : interrupt FSM states (state bit doubles as EXL)
//   - HANDLER_VEC_DEF : default interrupt handler entry address
package cpu_defs;

  localparam logic [31:0] HANDLER_VEC_DEF = 32'h0000_4180;

  typedef enum logic [2:0] {
    NPC_PC4  = 3'd0,
    NPC_BR   = 3'd1,
    NPC_JJAL = 3'd2,
    NPC_JR   = 3'd3,
    NPC_JI   = 3'd4
  } npc_sel_e;

  // Encoded so the state register bit is directly the EXL flag.
  typedef enum logic {
    ST_RUN = 1'b0,
    ST_EXC = 1'b1
  } fsm_st_e;

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: next-PC selection with single-level interrupt entry/return.
//   Inputs : Clk, Reset (async, active-low), Stall, Jtype[2:0], Jump_in_D,
//            PC_F[31:0], PC_D[31:0], Int_req, Int_en, Eret
//   Outputs: En (PC write enable), NPC_ctrl[2:0], JI[31:0] (handler or EPC),
//            EPC[31:0], EXL, BD, Flush_FD
// All outputs other than EPC/EXL/BD are a combinational decode of the
// registered state and the current inputs (zero-cycle latency).
module fetch_ctrl
  import cpu_defs::*;
#(
  parameter logic [31:0] HANDLER_VEC = HANDLER_VEC_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic [2:0]  Jtype,
  input  logic        Jump_in_D,
  input  logic [31:0] PC_F,
  input  logic [31:0] PC_D,
  input  logic        Int_req,
  input  logic        Int_en,
  input  logic        Eret,
  output logic        En,
  output logic [2:0]  NPC_ctrl,
  output logic [31:0] JI,
  output logic [31:0] EPC,
  output logic        EXL,
  output logic        BD,
  output logic        Flush_FD
);

  fsm_st_e     state_q, state_d;
  logic        pend_q, pend_d;
  logic [31:0] epc_q, epc_d;
  logic        bd_q, bd_d;

  logic        int_entry;
  logic        int_ret;
  npc_sel_e    jtype_sel;

  // Reserved redirect codes 4-7 collapse to plain PC+4.
  always_comb begin
    jtype_sel = NPC_PC4;
    case (Jtype)
      3'd1:    jtype_sel = NPC_BR;
      3'd2:    jtype_sel = NPC_JJAL;
      3'd3:    jtype_sel = NPC_JR;
      default: jtype_sel = NPC_PC4;
    endcase
  end

  // Int_req is OR'd in so a request arriving in the entry cycle needs no
  // extra latch cycle. Reset gates both events so outputs stay benign.
  assign int_entry = Reset && (state_q == ST_RUN) && (pend_q || Int_req)
                     && Int_en && !Stall;
  assign int_ret   = Reset && (state_q == ST_EXC) && Eret && !Stall;

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q | Int_req;
    epc_d    = epc_q;
    bd_d     = bd_q;
    En       = 1'b1;
    NPC_ctrl = NPC_PC4;
    Flush_FD = 1'b0;
    JI       = (state_q == ST_EXC) ? epc_q : HANDLER_VEC;

    if (!Reset) begin
      // Outputs held at their reset values while reset is asserted.
      En       = 1'b1;
      NPC_ctrl = NPC_PC4;
      Flush_FD = 1'b0;
      JI       = HANDLER_VEC;
    end else if (int_entry) begin
      En       = 1'b1;
      NPC_ctrl = NPC_JI;
      Flush_FD = 1'b1;
      JI       = HANDLER_VEC;
      // A redirect in D is preserved by resuming at the branch itself.
      epc_d    = Jump_in_D ? PC_D : PC_F;
      bd_d     = Jump_in_D;
      pend_d   = 1'b0;
      state_d  = ST_EXC;
    end else if (int_ret) begin
      En       = 1'b1;
      NPC_ctrl = NPC_JI;
      Flush_FD = 1'b1;
      JI       = epc_q;
      state_d  = ST_RUN;
    end else if (Stall) begin
      En       = 1'b0;
      NPC_ctrl = NPC_PC4;
      Flush_FD = 1'b0;
    end else begin
      En       = 1'b1;
      NPC_ctrl = jtype_sel;
      Flush_FD = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_RUN;
      pend_q  <= 1'b0;
      epc_q   <= 32'h0;
      bd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      epc_q   <= epc_d;
      bd_q    <= bd_d;
    end
  end

  assign EXL = (state_q == ST_EXC);
  assign EPC = epc_q;
  assign BD  = bd_q;

endmodule
